// File: rtl/axi_packetizer.sv
// axi_packetizer: cuts a 32-bit sample stream into packets of programmable length with tlast.
// Ports: clk; reset (sync, active-low); clear (sync soft clear, keeps counters);
//        pkt_len (beats per packet, 0 selects DEFAULT_LEN, sampled at packet start);
//        i_t* input stream; o_t* registered output stream behind a 2-entry skid buffer;
//        short_pkt pulses when i_tlast closes a packet early;
//        pkt_count/short_count statistics, built only with AXI_PACKETIZER_STATS_EN (else tied to 0).
module axi_packetizer #(
    parameter int WIDTH       = 32,
    parameter int LEN_W       = 16,
    parameter int DEFAULT_LEN = 48
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [LEN_W-1:0] pkt_len,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic             short_pkt,
    output logic [31:0]      pkt_count,
    output logic [31:0]      short_count
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_PKT  = 1'b1;
    logic [0:0]       state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] beat_cnt;
    logic [LEN_W-1:0] cur_len;
    logic [LEN_W:0]   beat_num;
    logic [WIDTH-1:0] skid_data;
    logic             skid_last;
    logic             skid_valid;
    logic             acc;
    logic             emit_last;
    logic             out_free;
    // A beat dropped by clear is never counted as accepted.
    assign acc       = reset & ~clear & i_tvalid & i_tready;
    // In S_IDLE the incoming beat is beat 1 of a new packet with the freshly sampled length.
    assign cur_len   = (state == S_IDLE) ? ((pkt_len == '0) ? LEN_W'(DEFAULT_LEN) : pkt_len) : len_q;
    assign beat_num  = (state == S_IDLE) ? (LEN_W+1)'(1) : {1'b0, beat_cnt} + 1'b1;
    assign emit_last = i_tlast | (beat_num == {1'b0, cur_len});
    assign short_pkt = acc & i_tlast & (beat_num < {1'b0, cur_len});
    assign out_free  = ~o_tvalid | o_tready;
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            state      <= S_IDLE;
            len_q      <= '0;
            beat_cnt   <= '0;
            o_tvalid   <= 1'b0;
            o_tdata    <= '0;
            o_tlast    <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_last  <= 1'b0;
            i_tready   <= reset;
        end else begin
            if (acc) begin
                state    <= emit_last ? S_IDLE : S_PKT;
                beat_cnt <= beat_num[LEN_W-1:0];
                if (state == S_IDLE) len_q <= cur_len;
            end
            // Output register refills from the skid entry first to keep beat order.
            if (out_free) begin
                o_tvalid   <= skid_valid | acc;
                skid_valid <= 1'b0;
                if (skid_valid) begin
                    o_tdata <= skid_data;
                    o_tlast <= skid_last;
                end else if (acc) begin
                    o_tdata <= i_tdata;
                    o_tlast <= emit_last;
                end
            end else if (acc) begin
                skid_valid <= 1'b1;
                skid_data  <= i_tdata;
                skid_last  <= emit_last;
            end
            i_tready <= out_free | ~(skid_valid | acc);
        end
    end
`ifdef AXI_PACKETIZER_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            pkt_count   <= '0;
            short_count <= '0;
        end else begin
            if (o_tvalid && o_tready && o_tlast) pkt_count <= pkt_count + 1'b1;
            if (short_pkt) short_count <= short_count + 1'b1;
        end
    end
`else
    assign pkt_count   = '0;
    assign short_count = '0;
`endif
endmodule

// File: tb/tb_axi_packetizer.sv
// tb_axi_packetizer: randomized self-checking bench for axi_packetizer against a queue-based packet model.
module tb_axi_packetizer;
    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic [15:0] pkt_len;
    logic [31:0] i_tdata;
    logic        i_tlast;
    logic        i_tvalid;
    logic        i_tready;
    logic [31:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready;
    logic        short_pkt;
    logic [31:0] pkt_count;
    logic [31:0] short_count;

    axi_packetizer dut (
        .clk(clk), .reset(reset), .clear(clear), .pkt_len(pkt_len),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .short_pkt(short_pkt), .pkt_count(pkt_count), .short_count(short_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } beat_t;

    beat_t       q[$];
    int          total = 0;
    int          bad = 0;
    int          pos = 0;
    int          mlen = 0;
    int          mpkt = 0;
    int          mshort = 0;
    bit          live = 0;
    logic [31:0] seq = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: every accepted beat is queued with the tlast the packet rules give it;
    // the output must present the queue head, valid iff anything is in flight.
    always @(negedge clk) begin
        beat_t b;
        bit    exp_sh;
        if (!reset) begin
            q.delete();
            pos = 0;
            mpkt = 0;
            mshort = 0;
            live = 0;
        end else begin
            if (live) begin
                check("i_tready", i_tready, q.size() < 2);
                check("o_tvalid", o_tvalid, q.size() > 0);
                if (q.size() > 0) begin
                    check("o_tdata", o_tdata, q[0].d);
                    check("o_tlast", o_tlast, q[0].l);
                end
            end
            if (clear) begin
                check("short_clr", short_pkt, 0);
                q.delete();
                pos = 0;
            end else begin
                exp_sh = 0;
                if (o_tvalid && o_tready && q.size() > 0) begin
                    if (q[0].l) mpkt++;
                    void'(q.pop_front());
                end
                if (i_tvalid && i_tready) begin
                    if (pos == 0) mlen = (pkt_len == 0) ? 48 : int'(pkt_len);
                    pos++;
                    b.d = i_tdata;
                    b.l = i_tlast || pos == mlen;
                    exp_sh = i_tlast && pos < mlen;
                    if (b.l) pos = 0;
                    q.push_back(b);
                end
                if (exp_sh) mshort++;
                if (live) check("short_pkt", short_pkt, exp_sh);
            end
            live = 1;
        end
    end

    task automatic run(input int n, input int tl, input int vp, input int rp,
                       input int ca, input bit jit, input int maxc);
        int idx = 0;
        int cyc = 0;
        bit acc;
        bit cleared = 0;
        while (idx < n && cyc < maxc) begin
            if (jit) begin
                case ($urandom_range(2))
                    0: pkt_len = 16'd3;
                    1: pkt_len = 16'd7;
                    default: pkt_len = 16'd0;
                endcase
            end
            i_tvalid = $urandom_range(99) < vp;
            i_tdata = seq;
            i_tlast = (idx == tl);
            clear = (idx == ca) && !cleared;
            if (clear) cleared = 1;
            o_tready = $urandom_range(99) < rp;
            @(negedge clk);
            acc = i_tvalid && i_tready && !clear;
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                seq++;
            end
            cyc++;
        end
        clear = 0;
        i_tvalid = 0;
        i_tlast = 0;
        if (maxc >= 5000) check("run_done", idx, n);
    endtask

    task automatic drain_clear;
        i_tvalid = 0;
        o_tready = 1;
        for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
        #1;
        check("drain", q.size(), 0);
        clear = 1;
        @(posedge clk);
        #1;
        clear = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 0;
        clear = 0;
        pkt_len = 16'd48;
        i_tdata = 0;
        i_tlast = 0;
        i_tvalid = 0;
        o_tready = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_i_tready", i_tready, 0);
        check("rst_o_tvalid", o_tvalid, 0);
        check("rst_o_tdata", o_tdata, 0);
        check("rst_o_tlast", o_tlast, 0);
        check("rst_short", short_pkt, 0);
        check("rst_pkt_count", pkt_count, 0);
        check("rst_short_count", short_count, 0);
        reset = 1;
        run(200, -1, 100, 100, -1, 0, 5000);
        drain_clear();
        pkt_len = 16'd0;
        run(100, -1, 100, 100, -1, 0, 5000);
        drain_clear();
        pkt_len = 16'd1;
        run(20, -1, 100, 100, -1, 0, 5000);
        drain_clear();
        pkt_len = 16'd48;
        run(40, 19, 100, 100, -1, 0, 5000);
        drain_clear();
        run(48, 47, 100, 100, -1, 0, 5000);
        drain_clear();
        run(150, -1, 80, 50, -1, 0, 5000);
        run(100, -1, 100, 0, -1, 0, 5);
        run(60, 30, 100, 60, -1, 0, 5000);
        drain_clear();
        run(70, -1, 100, 100, 10, 0, 5000);
        drain_clear();
        run(120, 50, 90, 70, -1, 1, 5000);
        drain_clear();
        reset = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
        pkt_len = 16'd8;
        run(24, -1, 100, 100, -1, 0, 5000);
        run(4, 3, 100, 100, -1, 0, 5000);
        drain_clear();
        @(negedge clk);
`ifdef AXI_PACKETIZER_STATS_EN
        check("pkt_count", pkt_count, mpkt);
        check("short_count", short_count, mshort);
`else
        check("pkt_count", pkt_count, 0);
        check("short_count", short_count, 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi_packetizer.md
Name: axi_packetizer

Overview:
- Streaming stage that sits directly upstream of the zero-pad stage in the compute-engine clock domain.
- Takes a continuous or bursty stream of 32-bit samples and cuts it into packets of a programmable length, driving tlast on the final beat.
- Its output satisfies the zero-pad stage's input contract: every packet is ≤ the configured length, and tlast is always present.
- Registered output with a 2-entry skid buffer, so full throughput is sustained under back-pressure.

Parameters:
- WIDTH, 32, sample/data width in bits.
- LEN_W, 16, width of the packet-length field.
- DEFAULT_LEN, 48, packet length used when pkt_len == 0.

Ports:
- clk  in  1  compute-engine clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (reset == 0 resets).
- clear  in  1  synchronous, active-high soft clear.
- pkt_len  in  LEN_W  requested packet length in beats; sampled at packet start.
- i_tdata  in  WIDTH  input sample.
- i_tlast  in  1  upstream burst end; forces an early packet end.
- i_tvalid  in  1  input valid.
- i_tready  out  1  input ready.
- o_tdata  out  WIDTH  output sample.
- o_tlast  out  1  last beat of packet.
- o_tvalid  out  1  output valid.
- o_tready  in  1  downstream ready.
- short_pkt  out  1  one-cycle pulse when a packet closes before reaching its length.
- pkt_count  out  32  emitted-packet counter (optional feature).
- short_count  out  32  short-packet counter (optional feature).

Behaviour:
- Reset (reset == 0 on a rising edge):
  - o_tvalid = 0, o_tdata = 0, o_tlast = 0, short_pkt = 0, i_tready = 0, counters = 0, skid empty, state = S_IDLE.
  - i_tready goes high on the first cycle after reset is released.
- Reset mid-packet discards the partial packet. No tlast is emitted for it.
- Handshake rules:
  - A transfer occurs when valid & ready are both high on a rising edge.
  - o_tvalid, once asserted, holds with o_tdata/o_tlast stable until accepted.
  - i_tready = !skid_full; it is registered and does not depend combinationally on o_tready.
- Latency: an accepted input beat appears on the output on the next cycle when the buffer is empty. Sustained throughput is 1 beat/cycle with o_tready held high.
- State machine:
  - S_IDLE: waiting for the first beat. On an accepted beat, latch len_q = (pkt_len == 0 ? DEFAULT_LEN : pkt_len) and set beat_cnt = 1.
    - If len_q == 1 or i_tlast is set, that beat carries tlast and the FSM stays in S_IDLE.
    - Otherwise go to S_PKT.
  - S_PKT: each accepted beat increments beat_cnt. The beat is marked tlast when beat_cnt + 1 == len_q or when i_tlast is set; that beat returns the FSM to S_IDLE.
- pkt_len changes while in S_PKT have no effect until the next packet.
- short_pkt:
  - Pulses for one cycle, coincident with the input acceptance of a beat where i_tlast = 1 and beat_cnt + 1 < len_q.
  - If i_tlast coincides with the length boundary, a single tlast is emitted and short_pkt stays 0.
- beat_cnt is LEN_W bits wide. The maximum length is 2^LEN_W − 1; the counter never wraps within a packet.
- clear (while reset is high) has the same effect as reset on the FSM, the skid buffer and o_tvalid. The counters are preserved. clear has priority over a simultaneous input transfer, and that input beat is dropped.
- i_tvalid low mid-packet inserts bubbles but does not end the packet.

Optional Feature:
- Macro AXI_PACKETIZER_STATS_EN.
- When defined:
  - pkt_count increments on each output beat accepted with o_tlast = 1.
  - short_count increments on each short_pkt pulse.
  - Both are 32-bit, wrap 0xFFFFFFFF → 0, and are cleared only by reset.
- When undefined: pkt_count and short_count are tied to 0 and no counter logic is built.

Test Plan:
- pkt_len = 48, 200 continuous beats (data = index), o_tready = 1 → tlast on beats 47, 95, 143, 191. The final 8 beats stay open with no tlast. Zero bubbles after the first-beat latency of 1 cycle.
- pkt_len = 0 → packets use DEFAULT_LEN = 48. pkt_len = 1 → tlast on every beat.
- pkt_len = 48, i_tlast on beat 19 → 20-beat packet with tlast on beat 19 and a single short_pkt pulse. With i_tlast on beat 47 instead → one 48-beat packet and short_pkt = 0.
- pkt_len = 48, o_tready toggled by a random pattern and stalled for 5 cycles → no data loss, duplication or reordering. o_tdata/o_tlast stay stable while stalled. i_tready deasserts only when the skid buffer is full.
- clear pulsed at beat 10 of a 48-beat packet → o_tvalid = 0 the next cycle. The next accepted beat starts a fresh packet, whose tlast arrives 48 beats later.
- With AXI_PACKETIZER_STATS_EN, run 3 full packets and 1 short packet → pkt_count = 4, short_count = 1. Without the macro, both read 0.
